phy_reg_free_list: RTL and testbench
====================================

// Module: phy_reg_free_list
// PURPOSE
// - Physical-register free list: the producer of PhyRegisterId_T tags consumed by rename/dispatch.
// - Rename pops one free physical register per cycle for a new destination mapping.
// - Commit pushes back one stale physical register per cycle when an instruction retires.
// - Sits between the rename stage (alloc end) and the ROB commit logic (free end).
// - Circular FIFO of physical register indices with an occupancy counter.
// PARAMETERS
// - NUM_PHY_REGS   128  physical registers; index width clog2 = 7; id width 8 (msb = valid)
// - NUM_ARCH_REGS  32   arch regs; phys 0..NUM_ARCH_REGS-1 are the identity mappings at reset
// PORTS
// - clk              in   1  clock; all state updates on posedge
// - rst              in   1  synchronous, active-high reset
// - alloc_req_i      in   1  rename requests one physical register this cycle
// - alloc_ready_o    out  1  list non-empty (count_o != 0); registered state only
// - alloc_id_o       out  8  {alloc_ready_o, head index[6:0]}; msb is valid, as PhyRegisterId_T
// - free_valid_i     in   1  commit returns a register this cycle
// - free_id_i        in   8  PhyRegisterId_T to return; msb must be 1
// - count_o          out  8  number of free entries, 0..NUM_PHY_REGS-1
// - err_overflow_o   out  1  one-cycle pulse: free dropped (list full, id 0, or msb clear)
// - err_dblfree_o    out  1  one-cycle pulse: double free detected (macro only, else 0)
// BEHAVIOUR
// - Storage: NUM_PHY_REGS-entry array of 7-bit indices; head/tail 7-bit pointers; 8-bit count.
// - Reset: entry i = i+NUM_ARCH_REGS for i < NUM_PHY_REGS-NUM_ARCH_REGS (32..127); head=0; tail=96;
//   count_o=96; alloc_ready_o=1; alloc_id_o=8'h A0; err_* = 0.
// - Phys reg 0 is permanently bound to x0: it is never in the list, and a free of index 0 is dropped.
// - Alloc fire = alloc_req_i & alloc_ready_o.
//   - alloc_id_o is combinational from head; the consumer samples it in the fire cycle.
//   - On fire: head <= head+1 (wraps 127->0); count decrements.
//   - alloc_req_i while empty: no state change; alloc_id_o msb = 0.
// - Free fire = free_valid_i & free_id_i[7] & (free_id_i[6:0] != 0) & (count_o != NUM_PHY_REGS-1).
//   - On fire: mem[tail] <= free_id_i[6:0]; tail <= tail+1 (wraps); count increments.
//   - If free_valid_i is high but free does not fire: err_overflow_o = 1 next cycle, and no state change.
// - Simultaneous alloc fire + free fire: both happen; count unchanged.
// - No bypass: a register freed in cycle N is allocatable no earlier than cycle N+1.
//   - Empty list plus free in the same cycle: the alloc is not granted that cycle.
// - Full list (count=127) plus an alloc fire plus a free in the same cycle: the free is still dropped
//   (full is judged on registered count). Keeps the timing path short.
// - Reset asserted mid-operation: everything returns to the reset image next edge; in-flight inputs are ignored.
// - Invariant: count_o == (tail-head) mod 128, except when full, where head == tail+1.
// - No flush/checkpoint port. Misprediction recovery walks the ROB and returns registers via free_*.
// CONFIGURATION
// - MYRV64_FREELIST_DBLFREE_CHECK_EN defined:
//   - Adds a 128-bit is_free mask: reset value = bits 32..127 set.
//   - Alloc fire clears the bit; free fire sets it.
//   - A free of an index whose bit is already set is dropped (no push); err_dblfree_o pulses next cycle.
//   - A same-cycle alloc of index k and free of index k is legal: the alloc clears first, then the free sets.
// - Macro not defined: no mask; err_dblfree_o tied 0; double frees are pushed unchecked.
// TESTING
// - Reset, then drain the list:
//   - 96 back-to-back alloc_req_i -> ids 0xA0,0xA1,...,0xFF in order.
//   - count_o goes to 0; alloc_ready_o=0; alloc_id_o[7]=0.
// - Empty list, free 0x85 with alloc_req_i high in the same cycle:
//   - That cycle: no grant.
//   - Next cycle: alloc_id_o=0x85, count_o=1.
// - Wrap-around:
//   - Alloc 96; free ids 0x81..0xFF (127 frees).
//   - count_o=127; a 128th free of 0x81 -> err_overflow_o pulse, count stays 127.
// - Free of id 0x80 (p0) or of 0x05 (msb clear) -> dropped; err_overflow_o pulses; count unchanged.
// - Steady state, simultaneous alloc+free every cycle for 300 cycles:
//   - count_o stays 96.
//   - FIFO order preserved across the head/tail wrap.
// - Macro on, reset, then free 0xA0 (already free) -> err_dblfree_o=1 one cycle; count_o stays 96.
//   Macro off: count_o=97 and err_dblfree_o stays 0.

Source files
------------

// File: rtl/phy_reg_free_list_if.sv
// Alloc/free handshake bundle between rename, commit and the physical-register free list.
// slave = free list side, master = rename/commit side.
interface phy_reg_free_list_if;
    logic       alloc_req_i;
    logic       alloc_ready_o;
    logic [7:0] alloc_id_o;
    logic       free_valid_i;
    logic [7:0] free_id_i;
    logic [7:0] count_o;
    logic       err_overflow_o;
    logic       err_dblfree_o;

    modport slave (
        input  alloc_req_i, free_valid_i, free_id_i,
        output alloc_ready_o, alloc_id_o, count_o, err_overflow_o, err_dblfree_o
    );

    modport master (
        output alloc_req_i, free_valid_i, free_id_i,
        input  alloc_ready_o, alloc_id_o, count_o, err_overflow_o, err_dblfree_o
    );
endinterface

// File: rtl/phy_reg_free_list.sv
// Circular FIFO of free physical register indices feeding rename; commit returns stale registers.
// Optional double-free detection when MYRV64_FREELIST_DBLFREE_CHECK_EN is defined.
module phy_reg_free_list #(
    parameter int NUM_PHY_REGS  = 128,
    parameter int NUM_ARCH_REGS = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    phy_reg_free_list_if.slave   bus
);
    localparam int IDX_W = $clog2(NUM_PHY_REGS);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(NUM_PHY_REGS - 1);
    localparam logic [CNT_W-1:0] CNT_RESET = CNT_W'(NUM_PHY_REGS - NUM_ARCH_REGS);
    localparam logic [IDX_W-1:0] TAIL_RESET = IDX_W'(NUM_PHY_REGS - NUM_ARCH_REGS);

    logic [IDX_W-1:0] r_mem [NUM_PHY_REGS];
    logic [IDX_W-1:0] r_head;
    logic [IDX_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic             r_err_ovf;

    logic             w_ready;
    logic [IDX_W-1:0] w_alloc_idx;
    logic [IDX_W-1:0] w_free_idx;
    logic             w_alloc_fire;
    logic             w_free_ok;
    logic             w_free_fire;
    logic             w_dbl;
    logic [CNT_W-1:0] w_count_next;

    assign w_ready      = (r_count != {CNT_W{1'b0}});
    assign w_alloc_idx  = r_mem[r_head];
    assign w_free_idx   = bus.free_id_i[IDX_W-1:0];
    assign w_alloc_fire = bus.alloc_req_i & w_ready;
    // Full is judged on registered count only, so a same-cycle alloc never makes room for a free.
    assign w_free_ok    = bus.free_valid_i & bus.free_id_i[7] &
                          (w_free_idx != {IDX_W{1'b0}}) & (r_count != CNT_FULL);
    assign w_free_fire  = w_free_ok & ~w_dbl;

`ifdef MYRV64_FREELIST_DBLFREE_CHECK_EN
    logic [NUM_PHY_REGS-1:0] r_is_free;
    logic [NUM_PHY_REGS-1:0] w_mask_next;
    logic                    r_err_dbl;

    // A same-cycle alloc of the same index clears the bit before the free is judged.
    assign w_dbl = w_free_ok & r_is_free[w_free_idx] &
                   ~(w_alloc_fire & (w_alloc_idx == w_free_idx));

    // Next free-mask: alloc clears, then free sets.
    always_comb begin
        w_mask_next = r_is_free;
        if (w_alloc_fire) begin
            w_mask_next[w_alloc_idx] = 1'b0;
        end else begin
            w_mask_next[w_alloc_idx] = r_is_free[w_alloc_idx];
        end
        if (w_free_fire) begin
            w_mask_next[w_free_idx] = 1'b1;
        end else begin
            w_mask_next[w_free_idx] = w_mask_next[w_free_idx];
        end
    end

    // Free-mask and double-free pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_PHY_REGS; i++) begin
                r_is_free[i] <= (i >= NUM_ARCH_REGS) ? 1'b1 : 1'b0;
            end
            r_err_dbl <= 1'b0;
        end else begin
            r_is_free <= w_mask_next;
            r_err_dbl <= w_dbl;
        end
    end

    assign bus.err_dblfree_o = r_err_dbl;
`else
    assign w_dbl             = 1'b0;
    assign bus.err_dblfree_o = 1'b0;
`endif

    // Occupancy next-state from the two fire strobes.
    always_comb begin
        w_count_next = r_count;
        case ({w_alloc_fire, w_free_fire})
            2'b10:   w_count_next = r_count - CNT_W'(1);
            2'b01:   w_count_next = r_count + CNT_W'(1);
            default: w_count_next = r_count;
        endcase
    end

    // Pointers, occupancy and overflow pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head    <= {IDX_W{1'b0}};
            r_tail    <= TAIL_RESET;
            r_count   <= CNT_RESET;
            r_err_ovf <= 1'b0;
        end else begin
            if (w_alloc_fire) begin
                r_head <= r_head + IDX_W'(1);
            end
            if (w_free_fire) begin
                r_tail <= r_tail + IDX_W'(1);
            end
            r_count   <= w_count_next;
            r_err_ovf <= bus.free_valid_i & ~w_free_ok;
        end
    end

    // Index storage; reset image holds the non-architectural registers in ascending order.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_PHY_REGS; i++) begin
                r_mem[i] <= (i < NUM_PHY_REGS - NUM_ARCH_REGS) ? IDX_W'(i + NUM_ARCH_REGS)
                                                               : {IDX_W{1'b0}};
            end
        end else if (w_free_fire) begin
            r_mem[r_tail] <= w_free_idx;
        end
    end

    assign bus.alloc_ready_o  = w_ready;
    assign bus.alloc_id_o     = {w_ready, w_alloc_idx};
    assign bus.count_o        = r_count;
    assign bus.err_overflow_o = r_err_ovf;
endmodule

// File: tb/tb_phy_reg_free_list.sv
// Directed bench for phy_reg_free_list: drain, empty/free race, wrap/full, bad frees, steady state, double free.
module tb_phy_reg_free_list;
    logic clk;
    logic rst;
    int   n_total;
    int   n_bad;

    phy_reg_free_list_if bus ();

    phy_reg_free_list dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        bus.alloc_req_i  = 1'b0;
        bus.free_valid_i = 1'b0;
        bus.free_id_i    = 8'h00;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drain_quiet();
        for (int i = 0; i < 96; i++) begin
            bus.alloc_req_i = 1'b1;
            @(negedge clk);
        end
        bus.alloc_req_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_total++;
        if (bus.count_o !== 8'd96) begin
            n_bad++; $display("FAIL reset_count got=%0d exp=96", bus.count_o);
        end
        n_total++;
        if (bus.alloc_ready_o !== 1'b1) begin
            n_bad++; $display("FAIL reset_ready got=%b exp=1", bus.alloc_ready_o);
        end
        n_total++;
        if (bus.alloc_id_o !== 8'hA0) begin
            n_bad++; $display("FAIL reset_id got=%h exp=a0", bus.alloc_id_o);
        end
        n_total++;
        if ({bus.err_overflow_o, bus.err_dblfree_o} !== 2'b00) begin
            n_bad++; $display("FAIL reset_err got=%b exp=00", {bus.err_overflow_o, bus.err_dblfree_o});
        end
    endtask

    task automatic test_drain();
        logic [7:0] exp_id;
        for (int i = 0; i < 96; i++) begin
            exp_id = 8'hA0 + 8'(i);
            n_total++;
            if (bus.alloc_id_o !== exp_id) begin
                n_bad++; $display("FAIL drain_id[%0d] got=%h exp=%h", i, bus.alloc_id_o, exp_id);
            end
            bus.alloc_req_i = 1'b1;
            @(negedge clk);
        end
        bus.alloc_req_i = 1'b0;
        n_total++;
        if (bus.count_o !== 8'd0) begin
            n_bad++; $display("FAIL drain_count got=%0d exp=0", bus.count_o);
        end
        n_total++;
        if (bus.alloc_ready_o !== 1'b0) begin
            n_bad++; $display("FAIL drain_ready got=%b exp=0", bus.alloc_ready_o);
        end
        n_total++;
        if (bus.alloc_id_o[7] !== 1'b0) begin
            n_bad++; $display("FAIL drain_id_msb got=%b exp=0", bus.alloc_id_o[7]);
        end
    endtask

    task automatic test_empty_free_alloc();
        bus.alloc_req_i  = 1'b1;
        bus.free_valid_i = 1'b1;
        bus.free_id_i    = 8'h85;
        @(negedge clk);
        bus.free_valid_i = 1'b0;
        bus.alloc_req_i  = 1'b0;
        n_total++;
        if (bus.count_o !== 8'd1) begin
            n_bad++; $display("FAIL empty_free_count got=%0d exp=1", bus.count_o);
        end
        n_total++;
        if (bus.alloc_id_o !== 8'h85) begin
            n_bad++; $display("FAIL empty_free_id got=%h exp=85", bus.alloc_id_o);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        drain_quiet();
        for (int i = 0; i < 127; i++) begin
            bus.free_valid_i = 1'b1;
            bus.free_id_i    = 8'h81 + 8'(i);
            @(negedge clk);
        end
        bus.free_valid_i = 1'b0;
        n_total++;
        if (bus.count_o !== 8'd127) begin
            n_bad++; $display("FAIL wrap_full_count got=%0d exp=127", bus.count_o);
        end
        bus.free_valid_i = 1'b1;
        bus.free_id_i    = 8'h81;
        @(negedge clk);
        bus.free_valid_i = 1'b0;
        n_total++;
        if ({bus.err_overflow_o, bus.count_o} !== {1'b1, 8'd127}) begin
            n_bad++; $display("FAIL wrap_overflow got=%b/%0d exp=1/127", bus.err_overflow_o, bus.count_o);
        end
        n_total++;
        if (bus.alloc_id_o !== 8'h81) begin
            n_bad++; $display("FAIL wrap_head_id got=%h exp=81", bus.alloc_id_o);
        end
        // Full list: alloc fires, same-cycle free is still dropped.
        bus.alloc_req_i  = 1'b1;
        bus.free_valid_i = 1'b1;
        bus.free_id_i    = 8'h90;
        @(negedge clk);
        bus.alloc_req_i  = 1'b0;
        bus.free_valid_i = 1'b0;
        n_total++;
        if ({bus.err_overflow_o, bus.count_o, bus.alloc_id_o} !== {1'b1, 8'd126, 8'h82}) begin
            n_bad++; $display("FAIL full_alloc_free got=%b/%0d/%h exp=1/126/82",
                              bus.err_overflow_o, bus.count_o, bus.alloc_id_o);
        end
        @(negedge clk);
        n_total++;
        if (bus.err_overflow_o !== 1'b0) begin
            n_bad++; $display("FAIL wrap_ovf_pulse got=%b exp=0", bus.err_overflow_o);
        end
    endtask

    task automatic test_bad_free();
        logic [7:0] bad_ids [2];
        bad_ids[0] = 8'h80;
        bad_ids[1] = 8'h05;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            bus.free_valid_i = 1'b1;
            bus.free_id_i    = bad_ids[k];
            @(negedge clk);
            bus.free_valid_i = 1'b0;
            n_total++;
            if ({bus.err_overflow_o, bus.count_o} !== {1'b1, 8'd96}) begin
                n_bad++; $display("FAIL bad_free_%h got=%b/%0d exp=1/96", bad_ids[k], bus.err_overflow_o, bus.count_o);
            end
            @(negedge clk);
            n_total++;
            if (bus.err_overflow_o !== 1'b0) begin
                n_bad++; $display("FAIL bad_free_pulse_%h got=%b exp=0", bad_ids[k], bus.err_overflow_o);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] q [$];
        logic [6:0] front;
        do_reset();
        for (int i = 32; i < 128; i++) q.push_back(7'(i));
        for (int c = 0; c < 300; c++) begin
            front = q.pop_front();
            n_total++;
            if ({bus.count_o, bus.alloc_id_o} !== {8'd96, 1'b1, front}) begin
                n_bad++; $display("FAIL steady[%0d] got=%0d/%h exp=96/%h", c, bus.count_o, bus.alloc_id_o, {1'b1, front});
            end
            bus.alloc_req_i  = 1'b1;
            bus.free_valid_i = 1'b1;
            bus.free_id_i    = {1'b1, front};
            q.push_back(front);
            @(negedge clk);
        end
        bus.alloc_req_i  = 1'b0;
        bus.free_valid_i = 1'b0;
        n_total++;
        if (bus.count_o !== 8'd96) begin
            n_bad++; $display("FAIL steady_end_count got=%0d exp=96", bus.count_o);
        end
    endtask

    task automatic test_dblfree();
        do_reset();
        bus.free_valid_i = 1'b1;
        bus.free_id_i    = 8'hA0;
        @(negedge clk);
        bus.free_valid_i = 1'b0;
`ifdef MYRV64_FREELIST_DBLFREE_CHECK_EN
        n_total++;
        if ({bus.err_dblfree_o, bus.count_o} !== {1'b1, 8'd96}) begin
            n_bad++; $display("FAIL dblfree got=%b/%0d exp=1/96", bus.err_dblfree_o, bus.count_o);
        end
        @(negedge clk);
        n_total++;
        if (bus.err_dblfree_o !== 1'b0) begin
            n_bad++; $display("FAIL dblfree_pulse got=%b exp=0", bus.err_dblfree_o);
        end
`else
        n_total++;
        if ({bus.err_dblfree_o, bus.count_o} !== {1'b0, 8'd97}) begin
            n_bad++; $display("FAIL dblfree_off got=%b/%0d exp=0/97", bus.err_dblfree_o, bus.count_o);
        end
`endif
        n_total++;
        if (bus.err_overflow_o !== 1'b0) begin
            n_bad++; $display("FAIL dblfree_ovf got=%b exp=0", bus.err_overflow_o);
        end
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        test_reset();
        test_drain();
        test_empty_free_alloc();
        test_wrap();
        test_bad_free();
        test_back_to_back();
        test_dblfree();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
